controlador_juego: RTL and testbench

- Sequencing FSM for the 6x7 four-in-a-row game. Owns the board register and alternates turns between player 1 and player 2.
- Applies gravity when a piece drops. Runs a per-turn timeout with an automatic move.
- Consults the external combinational win detector (detector_victoria) after every placement and declares win or draw.
- Sits between the input/debounce logic and the display/detector.

---
 rtl/juego_pkg.sv | 41 ++++
 rtl/detector_victoria.sv | 52 +++++
 rtl/temporizador_turno.sv | 37 +++
 rtl/controlador_juego.sv | 163 ++++++++++++++++
 tb/tb_controlador_juego.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/juego_pkg.sv
// Shared types and constants for the four-in-a-row controller and its win detector.
package juego_pkg;

    localparam int FILAS     = 6;
    localparam int COLUMNAS  = 7;
    localparam int MAX_MOVES = 42;

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        J1    = 2'd1,
        J2    = 2'd2
    } celda_t;

    // Row 0 is the top of the board, column 0 the leftmost.
    typedef logic [0:FILAS-1][0:COLUMNAS-1][1:0] tablero_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TURN  = 3'd1,
        PLACE = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        DRAW  = 3'd5
    } estado_t;

    // Leftmost column whose top cell is still empty.
    function automatic logic [2:0] primera_columna_libre(input tablero_t t);
        logic [2:0] col;
        logic       hallada;
        col     = 3'd0;
        hallada = 1'b0;
        for (int c = 0; c < COLUMNAS; c++) begin
            if (!hallada && t[0][c] == VACIO) begin
                col     = 3'(c);
                hallada = 1'b1;
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/detector_victoria.sv
// Combinational four-in-line detector over the whole board.
module detector_victoria
    import juego_pkg::*;
(
    input  tablero_t   tablero,
    output logic       hay_ganador,
    output logic [1:0] jugador_ganador
);

    function automatic logic cuatro(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] d);
        return (a != 2'd0) && (a == b) && (a == c) && (a == d);
    endfunction

    always_comb begin
        hay_ganador     = 1'b0;
        jugador_ganador = 2'd0;
        for (int r = 0; r < FILAS; r++) begin
            for (int c = 0; c <= COLUMNAS - 4; c++) begin
                if (cuatro(tablero[r][c], tablero[r][c+1], tablero[r][c+2], tablero[r][c+3])) begin
                    hay_ganador     = 1'b1;
                    jugador_ganador = tablero[r][c];
                end
            end
        end
        for (int r = 0; r <= FILAS - 4; r++) begin
            for (int c = 0; c < COLUMNAS; c++) begin
                if (cuatro(tablero[r][c], tablero[r+1][c], tablero[r+2][c], tablero[r+3][c])) begin
                    hay_ganador     = 1'b1;
                    jugador_ganador = tablero[r][c];
                end
            end
        end
        for (int r = 0; r <= FILAS - 4; r++) begin
            for (int c = 0; c <= COLUMNAS - 4; c++) begin
                if (cuatro(tablero[r][c], tablero[r+1][c+1], tablero[r+2][c+2], tablero[r+3][c+3])) begin
                    hay_ganador     = 1'b1;
                    jugador_ganador = tablero[r][c];
                end
            end
        end
        for (int r = 0; r <= FILAS - 4; r++) begin
            for (int c = 3; c < COLUMNAS; c++) begin
                if (cuatro(tablero[r][c], tablero[r+1][c-1], tablero[r+2][c-2], tablero[r+3][c-3])) begin
                    hay_ganador     = 1'b1;
                    jugador_ganador = tablero[r][c];
                end
            end
        end
    end

endmodule

// File: rtl/temporizador_turno.sv
// Per-turn elapsed-cycle counter; saturates at TURN_CYCLES-1 and flags expiry there.
module temporizador_turno #(
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [25:0] cnt,
    output logic        expirado
);

    localparam logic [25:0] LIMITE = 26'(TURN_CYCLES - 1);

    logic [25:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != LIMITE) begin
            cnt_d = cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign expirado = (cnt_q == LIMITE);

endmodule

// File: rtl/controlador_juego.sv
// Game sequencing FSM: board ownership, gravity scan, turn timeout and win/draw resolution.
// state | meaning
// IDLE  | waiting for start
// TURN  | player to move; turn timer running
// PLACE | scanning the latched column upward for the first empty row
// CHECK | detector sees the new board; resolve win / draw / next turn
// WIN   | game over with a winner
// DRAW  | game over, board full with no line
module controlador_juego
    import juego_pkg::*;
#(
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        drop,
    input  logic [2:0]  col_sel,
    input  logic        hay_ganador,
    input  logic [1:0]  jugador_ganador,
    output tablero_t    tablero,
    output logic [1:0]  jugador_actual,
    output logic [2:0]  estado,
    output logic        game_over,
    output logic [1:0]  ganador,
    output logic        empate,
    output logic        move_err,
    output logic [25:0] timer_cnt
);

    estado_t     estado_q, estado_d;
    tablero_t    tablero_q, tablero_d;
    logic [1:0]  jugador_q, jugador_d;
    logic [1:0]  ganador_q, ganador_d;
    logic        empate_q, empate_d;
    logic        move_err_q, move_err_d;
    logic [5:0]  movs_q, movs_d;
    logic [2:0]  fila_q, fila_d;
    logic [2:0]  col_q, col_d;
    logic [7:0]  col_libre;
    logic        drop_ok;
    logic        timer_clr, timer_en, expirado;
    logic [25:0] cnt_turno;

    temporizador_turno #(.TURN_CYCLES(TURN_CYCLES)) u_temporizador (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (timer_en),
        .cnt      (cnt_turno),
        .expirado (expirado)
    );

    // Bit 7 stays 0 so col_sel == 7 reads as a full column.
    always_comb begin
        col_libre = '0;
        for (int c = 0; c < COLUMNAS; c++) begin
            col_libre[c] = (tablero_q[0][c] == VACIO);
        end
        drop_ok = drop && col_libre[col_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= IDLE;
            tablero_q  <= '0;
            jugador_q  <= J1;
            ganador_q  <= 2'd0;
            empate_q   <= 1'b0;
            move_err_q <= 1'b0;
            movs_q     <= '0;
            fila_q     <= 3'(FILAS - 1);
            col_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            tablero_q  <= tablero_d;
            jugador_q  <= jugador_d;
            ganador_q  <= ganador_d;
            empate_q   <= empate_d;
            move_err_q <= move_err_d;
            movs_q     <= movs_d;
            fila_q     <= fila_d;
            col_q      <= col_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        tablero_d  = tablero_q;
        jugador_d  = jugador_q;
        ganador_d  = ganador_q;
        empate_d   = empate_q;
        move_err_d = 1'b0;
        movs_d     = movs_q;
        fila_d     = fila_q;
        col_d      = col_q;
        timer_clr  = 1'b0;
        timer_en   = (estado_q == TURN);
        case (estado_q)
            IDLE, WIN, DRAW: begin
                if (start) begin
                    tablero_d = '0;
                    jugador_d = J1;
                    ganador_d = 2'd0;
                    empate_d  = 1'b0;
                    movs_d    = '0;
                    fila_d    = 3'(FILAS - 1);
                    timer_clr = 1'b1;
                    estado_d  = TURN;
                end
            end
            TURN: begin
                if (drop && !drop_ok) begin
                    move_err_d = 1'b1;
                end
                if (drop_ok) begin
                    col_d    = col_sel;
                    fila_d   = 3'(FILAS - 1);
                    estado_d = PLACE;
                end else if (expirado) begin
                    col_d    = primera_columna_libre(tablero_q);
                    fila_d   = 3'(FILAS - 1);
                    estado_d = PLACE;
                end
            end
            PLACE: begin
                if (tablero_q[fila_q][col_q] == VACIO) begin
                    tablero_d[fila_q][col_q] = jugador_q;
                    movs_d   = movs_q + 6'd1;
                    estado_d = CHECK;
                end else begin
                    fila_d = fila_q - 3'd1;
                end
            end
            CHECK: begin
                if (hay_ganador) begin
                    ganador_d = jugador_ganador;
                    estado_d  = WIN;
                end else if (movs_q == 6'(MAX_MOVES)) begin
                    empate_d = 1'b1;
                    estado_d = DRAW;
                end else begin
                    jugador_d = (jugador_q == J1) ? J2 : J1;
                    timer_clr = 1'b1;
                    estado_d  = TURN;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        tablero        = tablero_q;
        jugador_actual = jugador_q;
        estado         = estado_q;
        game_over      = (estado_q == WIN) || (estado_q == DRAW);
        ganador        = ganador_q;
        empate         = empate_q;
        move_err       = move_err_q;
        timer_cnt      = cnt_turno;
    end

endmodule

// File: tb/tb_controlador_juego.sv
// Bench for controlador_juego with the real detector; move-level reference model plus vector tables.
module tb_controlador_juego;
    import juego_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, drop;
    logic [2:0]  col_sel;
    logic        hay_ganador;
    logic [1:0]  jugador_ganador;
    tablero_t    tablero;
    logic [1:0]  jugador_actual, ganador;
    logic [2:0]  estado;
    logic        game_over, empate, move_err;
    logic [25:0] timer_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: board as plain ints, states as the published encoding.
    int mb[FILAS][COLUMNAS];
    int mjug, mest, mgan, memp, mmovs;

    typedef struct {
        int col;
        int err;
        int fila;
        int jug;
        int est;
    } vec_t;

    vec_t tab_col[8];
    vec_t tab_h[8];

    always #5 clk = ~clk;

    controlador_juego #(.TURN_CYCLES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .drop            (drop),
        .col_sel         (col_sel),
        .hay_ganador     (hay_ganador),
        .jugador_ganador (jugador_ganador),
        .tablero         (tablero),
        .jugador_actual  (jugador_actual),
        .estado          (estado),
        .game_over       (game_over),
        .ganador         (ganador),
        .empate          (empate),
        .move_err        (move_err),
        .timer_cnt       (timer_cnt)
    );

    detector_victoria u_det (
        .tablero         (tablero),
        .hay_ganador     (hay_ganador),
        .jugador_ganador (jugador_ganador)
    );

    task automatic chk(input string nombre, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    function automatic bit dentro(input int r, input int c);
        return (r >= 0) && (r < FILAS) && (c >= 0) && (c < COLUMNAS);
    endfunction

    function automatic int m_ganador();
        int dr[4];
        int dc[4];
        int k;
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int r = 0; r < FILAS; r++) begin
            for (int c = 0; c < COLUMNAS; c++) begin
                if (mb[r][c] != 0) begin
                    for (int d = 0; d < 4; d++) begin
                        k = 1;
                        while (k < 4 && dentro(r + k*dr[d], c + k*dc[d]) &&
                               mb[r + k*dr[d]][c + k*dc[d]] == mb[r][c]) k++;
                        if (k == 4) return mb[r][c];
                    end
                end
            end
        end
        return 0;
    endfunction

    function automatic int m_fila(input int col);
        for (int r = FILAS - 1; r >= 0; r--) begin
            if (mb[r][col] == 0) return r;
        end
        return -1;
    endfunction

    function automatic int m_izq();
        for (int c = 0; c < COLUMNAS; c++) begin
            if (mb[0][c] == 0) return c;
        end
        return 0;
    endfunction

    task automatic m_limpiar(input int est);
        for (int r = 0; r < FILAS; r++)
            for (int c = 0; c < COLUMNAS; c++) mb[r][c] = 0;
        mjug = 1; mmovs = 0; mgan = 0; memp = 0; mest = est;
    endtask

    task automatic m_apply(input int col);
        int r, g;
        r = m_fila(col);
        mb[r][col] = mjug;
        mmovs++;
        g = m_ganador();
        if (g != 0) begin
            mgan = g; mest = 4;
        end else if (mmovs == 42) begin
            memp = 1; mest = 5;
        end else begin
            mjug = 3 - mjug;
        end
    endtask

    task automatic comparar_modelo();
        tablero_t e;
        for (int r = 0; r < FILAS; r++)
            for (int c = 0; c < COLUMNAS; c++) e[r][c] = 2'(mb[r][c]);
        n_tests++;
        if (tablero !== e) begin
            n_fail++;
            $display("FAIL tablero: got %h, expected %h (t=%0t)", tablero, e, $time);
        end
        chk("jugador_actual", int'(jugador_actual), mjug);
        chk("estado", int'(estado), mest);
        chk("ganador", int'(ganador), mgan);
        chk("empate", int'(empate), memp);
        chk("game_over", int'(game_over), int'(mest == 4 || mest == 5));
    endtask

    task automatic pulso_start();
        bit reinicia;
        reinicia = (mest == 0 || mest == 4 || mest == 5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (reinicia) m_limpiar(1);
        comparar_modelo();
        if (reinicia) chk("timer_start", int'(timer_cnt), 0);
    endtask

    task automatic jugar(input int col, output int err, output int fila);
        int  t0, n;
        bit  en_turno, valida;
        en_turno = (mest == 1);
        valida   = en_turno && (col < COLUMNAS) && (mb[0][col] == 0);
        fila     = valida ? m_fila(col) : -1;
        t0       = int'(timer_cnt);
        col_sel  = 3'(col);
        drop     = 1'b1;
        @(posedge clk); #1;
        drop = 1'b0;
        err  = int'(move_err);
        if (en_turno && !valida) begin
            chk("move_err_pulso", err, 1);
            chk("timer_sigue", int'(timer_cnt), t0 + 1);
            @(posedge clk); #1;
            chk("move_err_fin", int'(move_err), 0);
            chk("timer_sigue2", int'(timer_cnt), t0 + 2);
        end else begin
            chk("move_err_cero", err, 0);
            if (valida) begin
                n = 0;
                while ((estado == 3'd2 || estado == 3'd3) && n < 12) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("latencia", n, 7 - fila);
                m_apply(col);
            end
        end
        comparar_modelo();
    endtask

    task automatic esperar_timeout();
        int t0, n, c, r;
        t0 = int'(timer_cnt);
        n  = 0;
        while (estado == 3'd1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_ciclos", n, 16 - t0);
        c = m_izq();
        r = m_fila(c);
        n = 0;
        while ((estado == 3'd2 || estado == 3'd3) && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_latencia", n, 7 - r);
        m_apply(c);
        comparar_modelo();
        if (mest == 1) chk("timer_reinicio", int'(timer_cnt), 0);
    endtask

    initial begin
        int e, f, n, col;
        int seq[$];
        int pa[3];
        int pb[3];

        tab_col[0] = '{2, 0,  5, 2, 1};
        tab_col[1] = '{2, 0,  4, 1, 1};
        tab_col[2] = '{2, 0,  3, 2, 1};
        tab_col[3] = '{2, 0,  2, 1, 1};
        tab_col[4] = '{2, 0,  1, 2, 1};
        tab_col[5] = '{2, 0,  0, 1, 1};
        tab_col[6] = '{2, 1, -1, 1, 1};
        tab_col[7] = '{7, 1, -1, 1, 1};

        tab_h[0] = '{0, 0,  5, 2, 1};
        tab_h[1] = '{0, 0,  4, 1, 1};
        tab_h[2] = '{1, 0,  5, 2, 1};
        tab_h[3] = '{1, 0,  4, 1, 1};
        tab_h[4] = '{2, 0,  5, 2, 1};
        tab_h[5] = '{2, 0,  4, 1, 1};
        tab_h[6] = '{3, 0,  5, 1, 4};
        tab_h[7] = '{4, 0, -1, 1, 4};

        rst = 1'b1; start = 1'b0; drop = 1'b0; col_sel = 3'd0;
        m_limpiar(0);
        #1;
        comparar_modelo();
        chk("reset_move_err", int'(move_err), 0);
        chk("reset_timer", int'(timer_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full column, then a rejected drop on it and on column 7.
        pulso_start();
        for (int i = 0; i < 8; i++) begin
            jugar(tab_col[i].col, e, f);
            chk("tabcol_err", e, tab_col[i].err);
            chk("tabcol_fila", f, tab_col[i].fila);
            chk("tabcol_jug", int'(jugador_actual), tab_col[i].jug);
            chk("tabcol_estado", int'(estado), tab_col[i].est);
        end
        chk("col2_fila0", int'(tablero[0][2]), 2);
        chk("col2_fila5", int'(tablero[5][2]), 1);

        // start is ignored mid-game.
        pulso_start();

        // Asynchronous reset while scanning in PLACE.
        col_sel = 3'd3; drop = 1'b1;
        @(posedge clk); #1;
        drop = 1'b0;
        chk("en_place", int'(estado), 2);
        #1 rst = 1'b1;
        #1;
        m_limpiar(0);
        comparar_modelo();
        chk("rst_move_err", int'(move_err), 0);
        chk("rst_timer", int'(timer_cnt), 0);
        @(posedge clk); #1;
        comparar_modelo();
        chk("rst_timer2", int'(timer_cnt), 0);
        rst = 1'b0;

        // Horizontal win on the bottom row; a later drop is ignored.
        pulso_start();
        for (int i = 0; i < 8; i++) begin
            jugar(tab_h[i].col, e, f);
            chk("tabh_err", e, tab_h[i].err);
            chk("tabh_fila", f, tab_h[i].fila);
            chk("tabh_jug", int'(jugador_actual), tab_h[i].jug);
            chk("tabh_estado", int'(estado), tab_h[i].est);
        end
        chk("win_ganador", int'(ganador), 1);
        chk("win_game_over", int'(game_over), 1);

        // Timeout auto-move, drop-over-timeout priority, auto-move skipping a full column.
        pulso_start();
        esperar_timeout();
        chk("auto_col0", int'(tablero[5][0]), 1);
        chk("auto_jug", int'(jugador_actual), 2);
        n = 0;
        while (timer_cnt != 26'd15 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("espera_limite", int'(timer_cnt), 15);
        jugar(3, e, f);
        chk("prioridad_drop", int'(tablero[5][3]), 2);
        chk("prioridad_col0", int'(tablero[4][0]), 0);
        for (int i = 0; i < 5; i++) jugar(0, e, f);
        esperar_timeout();
        chk("auto_col1", int'(tablero[5][1]), 2);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_limpiar(0);
        comparar_modelo();

        // 42-move draw: columns typed A/A/B/B/A/A/B with alternating stacks.
        pa = '{0, 1, 4};
        pb = '{2, 3, 6};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) seq.push_back(pa[p]);
            for (int i = 0; i < 6; i++) seq.push_back(pb[p]);
            seq.push_back(pa[p]);
        end
        for (int i = 0; i < 6; i++) seq.push_back(5);
        pulso_start();
        foreach (seq[i]) jugar(seq[i], e, f);
        chk("draw_estado", int'(estado), 5);
        chk("draw_empate", int'(empate), 1);
        chk("draw_ganador", int'(ganador), 0);
        pulso_start();
        chk("draw_reinicio_estado", int'(estado), 1);
        chk("draw_reinicio_jug", int'(jugador_actual), 1);

        // Randomised games against the model.
        for (int g = 0; g < 15; g++) begin
            n = 0;
            while (mest == 1 && n < 150) begin
                col = int'($urandom_range(0, 7));
                if ((col == 7 || mb[0][col] != 0) && timer_cnt >= 26'd10) col = m_izq();
                jugar(col, e, f);
                n++;
            end
            chk("partida_termina", int'(mest == 4 || mest == 5), 1);
            jugar(int'($urandom_range(0, 7)), e, f);
            pulso_start();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
